// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry defaults, line layout and width helper.
package cache_pkg;
   localparam int WORD_SIZE       = 32;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK;
   localparam int NUM_SETS        = 64;
   localparam int NUM_WAYS        = 2;
   localparam int TAG_WIDTH       = 24;
   localparam int INDEX_WIDTH     = $clog2(NUM_SETS);
   localparam int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK);

   typedef struct packed {
      logic                  valid;
      logic                  dirty;
      logic [TAG_WIDTH-1:0]  tag;
      logic [BLOCK_SIZE-1:0] data;
   } cache_line_t;

   // A way select is never narrower than one bit, even for a direct-mapped cache.
   function automatic int way_bits(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set age-based LRU tracking and victim selection.
module cache_lru
   import cache_pkg::*;
#(
   parameter int NUM_SETS    = cache_pkg::NUM_SETS,
   parameter int NUM_WAYS    = cache_pkg::NUM_WAYS,
   parameter int INDEX_WIDTH = $clog2(NUM_SETS),
   localparam int WAY_W      = way_bits(NUM_WAYS)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INDEX_WIDTH-1:0] index,
   input  logic [NUM_WAYS-1:0]    set_valid,
   input  logic                   upd,
   input  logic [WAY_W-1:0]       upd_way,
   output logic [WAY_W-1:0]       victim
);
   logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];
   logic [WAY_W-1:0] old_age;

   assign old_age = age[index][upd_way];

   // Oldest way is the default; any invalid way overrides, lowest number winning.
   always_comb begin
      victim = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (age[index][w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!set_valid[w]) victim = WAY_W'(w);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
               age[s][w] <= WAY_W'(w);
      end else if (upd) begin
         for (int w = 0; w < NUM_WAYS; w++)
            age[index][w] <= (WAY_W'(w) == upd_way) ? '0 :
                             (age[index][w] < old_age) ? age[index][w] + 1'b1 : age[index][w];
      end
endmodule

// File: rtl/set_assoc_cache_memory.sv
// set_assoc_cache_memory: N-way set-associative cache array with registered lookup, write and refill.
module set_assoc_cache_memory
   import cache_pkg::*;
#(
   parameter int WORD_SIZE       = cache_pkg::WORD_SIZE,
   parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
   parameter int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
   parameter int NUM_SETS        = cache_pkg::NUM_SETS,
   parameter int NUM_WAYS        = cache_pkg::NUM_WAYS,
   parameter int TAG_WIDTH       = cache_pkg::TAG_WIDTH,
   parameter int INDEX_WIDTH     = $clog2(NUM_SETS),
   parameter int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK),
   localparam int WAY_W          = way_bits(NUM_WAYS)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [TAG_WIDTH-1:0]    tag,
   input  logic [INDEX_WIDTH-1:0]  index,
   input  logic [OFFSET_WIDTH-1:0] blk_offset,
   input  logic                    req_type,
   input  logic                    read_en_cache,
   input  logic                    write_en_cache,
   input  logic                    refill,
   input  logic [BLOCK_SIZE-1:0]   data_in_mem,
   input  logic [WORD_SIZE-1:0]    data_in,
   output logic                    hit,
   output logic [WORD_SIZE-1:0]    data_out,
   output logic                    dirty_bit,
   output logic [BLOCK_SIZE-1:0]   dirty_block_out,
   output logic [TAG_WIDTH-1:0]    evict_tag,
   output logic [WAY_W-1:0]        victim_way,
   output logic                    done_cache
);
   logic                  valid    [NUM_SETS][NUM_WAYS];
   logic                  dirty    [NUM_SETS][NUM_WAYS];
   logic [TAG_WIDTH-1:0]  tag_arr  [NUM_SETS][NUM_WAYS];
   logic [BLOCK_SIZE-1:0] data_arr [NUM_SETS][NUM_WAYS];

   logic [NUM_WAYS-1:0] set_valid;
   logic                hit_any, do_fill, do_write, do_read, lookup_hit, lookup_miss;
   logic [WAY_W-1:0]    hit_way, victim;
   logic [WORDS_PER_BLOCK-1:0][WORD_SIZE-1:0] hit_w, fill_w, wr_w;

   always_comb begin
      set_valid = '0;
      hit_any   = 1'b0;
      hit_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         set_valid[w] = valid[index][w];
         if (valid[index][w] && tag_arr[index][w] == tag) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   assign do_fill     = refill && write_en_cache;
   assign do_write    = write_en_cache && !refill;
   assign do_read     = read_en_cache && !write_en_cache;
   assign lookup_hit  = (do_write || do_read) && hit_any;
   assign lookup_miss = (do_write || do_read) && !hit_any;
   assign hit_w       = data_arr[index][hit_way];

   always_comb begin
      fill_w = data_in_mem;
      wr_w   = hit_w;
      wr_w[blk_offset] = data_in;
      if (req_type) fill_w[blk_offset] = data_in;
   end

   cache_lru #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .INDEX_WIDTH(INDEX_WIDTH)) u_lru (
      .clk       (clk),
      .rst_n     (rst_n),
      .index     (index),
      .set_valid (set_valid),
      .upd       (do_fill || lookup_hit),
      .upd_way   (do_fill ? victim : hit_way),
      .victim    (victim)
   );

   // Line contents are never reset; only valid/dirty state decides what is live.
   always_ff @(posedge clk)
      if (do_fill) begin
         tag_arr[index][victim]  <= tag;
         data_arr[index][victim] <= fill_w;
      end else if (lookup_hit && do_write) begin
         data_arr[index][hit_way] <= wr_w;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid[s][w] <= 1'b0;
               dirty[s][w] <= 1'b0;
            end
         hit             <= 1'b0;
         data_out        <= '0;
         dirty_bit       <= 1'b0;
         dirty_block_out <= '0;
         evict_tag       <= '0;
         victim_way      <= '0;
         done_cache      <= 1'b0;
      end else begin
         done_cache <= do_fill || do_write || do_read;
         if (do_fill || lookup_miss) begin
            hit             <= 1'b0;
            victim_way      <= victim;
            evict_tag       <= tag_arr[index][victim];
            dirty_bit       <= dirty[index][victim];
            dirty_block_out <= data_arr[index][victim];
         end
         if (do_fill) begin
            valid[index][victim] <= 1'b1;
            dirty[index][victim] <= req_type;
            data_out             <= fill_w[blk_offset];
         end
         if (lookup_hit) begin
            hit       <= 1'b1;
            dirty_bit <= do_write || dirty[index][hit_way];
            if (do_write) dirty[index][hit_way] <= 1'b1;
            else data_out <= hit_w[blk_offset];
         end
      end
endmodule

// File: doc/set_assoc_cache_memory.md
SET_ASSOC_CACHE_MEMORY -- requirements
Module: set_assoc_cache_memory

Interface
REQ-001 SHALL have parameters: WORD_SIZE=32 (bits per word); WORDS_PER_BLOCK=4 (words per line); BLOCK_SIZE=WORD_SIZE*WORDS_PER_BLOCK (line bits); NUM_SETS=64 (sets); NUM_WAYS=2 (ways, power of 2, 1..8); TAG_WIDTH=24; INDEX_WIDTH=log2(NUM_SETS); OFFSET_WIDTH=log2(WORDS_PER_BLOCK).
REQ-002 SHALL use one clock and an asynchronous, active-low reset, ports named as below.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 tag, index, blk_offset  in  TAG_WIDTH/INDEX_WIDTH/OFFSET_WIDTH  request address fields.
REQ-006 req_type  in  1  0=read, 1=write.
REQ-007 read_en_cache, write_en_cache, refill  in  1 each  lookup-read, lookup-write, line-fill strobes.
REQ-008 data_in_mem  in  BLOCK_SIZE  fill line from memory; data_in  in  WORD_SIZE  store word.
REQ-009 hit  out  1; data_out  out  WORD_SIZE; dirty_bit  out  1 (victim dirty on miss); dirty_block_out  out  BLOCK_SIZE (victim line); evict_tag  out  TAG_WIDTH (victim tag); victim_way  out  log2(NUM_WAYS) (min 1 bit); done_cache  out  1 (one-cycle completion pulse).

Function
REQ-010 Priority per cycle SHALL be refill&write_en_cache > write_en_cache > read_en_cache; lower-priority strobes ignored that cycle.
REQ-011 Lookup: way hits iff valid and stored tag==tag in set index; at most one way hits.
REQ-012 All outputs SHALL be registered; results valid the edge after the strobe, with done_cache=1 for exactly that cycle.
REQ-013 Read hit: data_out=word blk_offset of hit way, hit=1, dirty_bit=hit line dirty; LRU update.
REQ-014 Write hit (write_en_cache, refill=0): word blk_offset of hit way <= data_in, dirty<=1, hit=1; LRU update; other words unchanged.
REQ-015 Miss (read or write, refill=0): hit=0, no array/LRU change; victim_way, evict_tag, dirty_bit, dirty_block_out SHALL describe the selected victim.
REQ-016 Victim: lowest-numbered invalid way, else way with age NUM_WAYS-1.
REQ-017 Refill (refill=1 & write_en_cache=1): victim line <= data_in_mem, tag<=tag, valid<=1; if req_type=1 word blk_offset <= data_in and dirty<=1, else dirty<=0; data_out = resulting word blk_offset; hit=0; LRU update to victim way.
REQ-018 LRU: per-set age per way (log2 NUM_WAYS bits); accessed way age<=0, ways with age below old age increment, others hold; ages stay a permutation of 0..NUM_WAYS-1.
REQ-019 NUM_WAYS=1 SHALL degenerate to direct-mapped behaviour (victim always way 0).
REQ-020 No strobe: outputs hold, done_cache=0.
REQ-021 Back-to-back strobes every cycle SHALL be accepted, each completing one cycle later; a refill followed next cycle by lookup of the same address SHALL hit.

Reset
REQ-022 rst_n low SHALL immediately clear all valid and dirty bits and set ages of way w to w in every set.
REQ-023 During/after reset: hit=0, dirty_bit=0, done_cache=0, data_out=0, dirty_block_out=0, evict_tag=0, victim_way=0; data/tag arrays not cleared.
REQ-024 Reset asserted mid-operation SHALL abort the pending result; no done_cache pulse for it.

Structure
REQ-025 WORD_SIZE, WORDS_PER_BLOCK, BLOCK_SIZE, NUM_SETS, NUM_WAYS, TAG_WIDTH, INDEX_WIDTH, OFFSET_WIDTH defaults and a line typedef (valid, dirty, tag, data) SHALL live in shared package cache_pkg.
REQ-026 LRU age storage, update and victim selection SHALL be sub-module cache_lru.

Verification (NUM_WAYS=2, defaults)
REQ-027 Reset, read tag 0xABCDE0 index 0 -> hit=0, victim_way=0, dirty_bit=0, done_cache pulse one cycle later.
REQ-028 Refill index 2 tag 0x1A2B3C req_type=0 data_in_mem word0=0xF0F0F0F0, then read offset 0 -> hit=1, data_out=0xF0F0F0F0, dirty_bit=0.
REQ-029 Write hit index 2 offset 3 data 0xCAFEBABE, then read offset 3 -> data_out=0xCAFEBABE, dirty_bit=1.
REQ-030 Fill both ways of index 4 (tags A then B), read A, miss tag C -> victim_way=way of B, evict_tag=B.
REQ-031 Dirty way evicted: miss on full set whose LRU way is dirty -> dirty_bit=1, dirty_block_out=stored line incl. written word.
REQ-032 rst_n low between strobe and next edge -> no done_cache; prior-filled line then misses (valid cleared).
